// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// PC and instruction-memory widths, the NOP encoding, and the IF/ID register payload.
package if_stage_pkg;

    localparam int          PC_W    = 32;
    localparam int          IMEM_AW = 10;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc_plus4;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    // Redirect targets are byte addresses; fetch only ever runs on word boundaries.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and counts valid deliveries.
// Latency: one cycle from fetch pc/instruction to if_id outputs.
// Backpressure: stall holds every field; bubble (flush/redirect) overrides stall and loads a NOP.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            bubble,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic [31:0]     fetch_instr,
    output if_id_t          if_id,
    output logic [31:0]     fetch_count
);

    logic [PC_W-1:0] fetch_pc_plus4;

    assign fetch_pc_plus4 = fetch_pc + PC_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id.pc       <= '0;
            if_id.pc_plus4 <= '0;
            if_id.instr    <= NOP_INSTR;
            if_id.valid    <= 1'b0;
            fetch_count    <= '0;
        end else if (bubble) begin
            // A killed slot still records where it came from, which helps debug traces.
            if_id.pc       <= fetch_pc;
            if_id.pc_plus4 <= fetch_pc_plus4;
            if_id.instr    <= NOP_INSTR;
            if_id.valid    <= 1'b0;
        end else if (!stall) begin
            if_id.pc       <= fetch_pc;
            if_id.pc_plus4 <= fetch_pc_plus4;
            if_id.instr    <= fetch_instr;
            if_id.valid    <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, PC register, and IF/ID register instance.
// Latency: instruction at pc in cycle N appears on if_id_* in cycle N+1.
// Backpressure: stall freezes pc and IF/ID; redirects still move pc; flush/redirect inject a bubble.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_plus4,
    output logic [31:0]        if_id_instr,
    output logic               if_id_valid,
    output logic [31:0]        fetch_count
);

    logic [PC_W-1:0] next_pc;
    logic            bubble;
    if_id_t          if_id;

    // Branch from EX is older than a jump from ID, so it takes precedence.
    always_comb begin
        next_pc = pc + PC_W'(4);
        if (branch_taken) begin
            next_pc = word_align(branch_target);
        end else if (jump) begin
            next_pc = word_align(jump_target);
        end else if (stall) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else begin
            pc <= next_pc;
        end
    end

    // Higher pc bits are ignored, so memory aliases every 4 KB.
    assign imem_addr = pc[IMEM_AW+1:2];
    assign bubble    = flush | branch_taken | jump;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .bubble      (bubble),
        .fetch_pc    (pc),
        .fetch_instr (imem_rdata),
        .if_id       (if_id),
        .fetch_count (fetch_count)
    );

    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_instr    = if_id.instr;
    assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized hazards
// compared each cycle against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_ipc, m_ip4, m_instr, m_cnt;
    logic        m_valid;

    if_stage #(
        .PC_RESET  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: distinctive, never equal to the NOP word.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0;
        m_instr = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},        pc,                     m_pc);
        chk({tag, ".imem_addr"}, {22'h0, imem_addr},     {22'h0, m_pc[11:2]});
        chk({tag, ".id_pc"},     if_id_pc,               m_ipc);
        chk({tag, ".id_pc4"},    if_id_pc_plus4,         m_ip4);
        chk({tag, ".id_instr"},  if_id_instr,            m_instr);
        chk({tag, ".id_valid"},  {31'h0, if_id_valid},   {31'h0, m_valid});
        chk({tag, ".count"},     fetch_count,            m_cnt);
    endtask

    // Called just after a falling edge: drive inputs, advance model, check at next falling edge.
    task automatic cycle(input string tag, input logic s, input logic f,
                         input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        logic [31:0] npc;
        stall = s; flush = f; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt;
        if (b)      npc = bt & 32'hFFFF_FFFC;
        else if (j) npc = jt & 32'hFFFF_FFFC;
        else if (s) npc = m_pc;
        else        npc = m_pc + 32'd4;
        @(posedge clk);
        if (f || b || j) begin
            m_ipc = m_pc; m_ip4 = m_pc + 32'd4; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
            m_instr = mem_word(m_pc[11:2]); m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        m_pc = npc;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch from PC_RESET
        idle("seq1");
        chk("seq1.valid_first", {31'h0, if_id_valid}, 32'h1);
        idle("seq2");
        idle("seq3");
        chk("seq.pc12", pc, 32'd12);
        chk("seq.count3", fetch_count, 32'd3);

        // Back up to pc = 8 via a jump, then stall two cycles
        cycle("jmp8", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4);
        idle("to8");
        chk("pre_stall.pc", pc, 32'd8);
        cycle("stall1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle("stall2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall.hold_pc", pc, 32'd8);
        chk("stall.hold_instr", if_id_instr, mem_word(10'd1));
        idle("resume");
        chk("resume.pc", pc, 32'd12);
        chk("resume.id_pc", if_id_pc, 32'd8);
        idle("to16");

        // Branch with unaligned target
        cycle("br43", 1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0, 32'h0);
        chk("br43.pc", pc, 32'h40);
        chk("br43.bubble", {31'h0, if_id_valid}, 32'h0);
        idle("after_br");
        chk("after_br.instr", if_id_instr, mem_word(10'h10));

        // Branch + jump + stall together
        cycle("br_jmp_stall", 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h80);
        chk("brjs.pc", pc, 32'h20);

        // Stall + flush: bubble, pc held
        cycle("stall_flush", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("sf.pc", pc, 32'h20);

        // PC wrap at the top of the address space
        cycle("to_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("top.imem_addr", {22'h0, imem_addr}, 32'h3FF);
        idle("wrap");
        chk("wrap.pc", pc, 32'h0);
        chk("wrap.imem_addr", {22'h0, imem_addr}, 32'h0);
        idle("post_wrap");

        // Asynchronous reset mid-cycle during a stall
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        idle("restart");
        chk("restart.id_pc", if_id_pc, 32'h0);
        chk("restart.pc", pc, 32'h4);

        // Randomized hazards
        for (int i = 0; i < 400; i++) begin
            logic        s, f, b, j;
            logic [31:0] bt, jt;
            s  = ($urandom_range(0, 99) < 25);
            f  = ($urandom_range(0, 99) < 10);
            b  = ($urandom_range(0, 99) < 8);
            j  = ($urandom_range(0, 99) < 8);
            bt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8191));
            jt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8191));
            cycle("rand", s, f, b, bt, j, jt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default `NOP (32'h0000_0000), instruction word inserted on bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hazard hold from ID; freezes PC and IF/ID register.
REQ-006 flush  input  1  kill the instruction currently being fetched (bubble into IF/ID).
REQ-007 branch_taken  input  1  redirect request from EX.
REQ-008 branch_target  input  32  branch destination byte address.
REQ-009 jump  input  1  redirect request from ID.
REQ-010 jump_target  input  32  jump destination byte address.
REQ-011 imem_addr  output  10  word address to instruction memory, equal to pc[11:2].
REQ-012 imem_rdata  input  32  instruction word; combinational return for imem_addr in the same cycle.
REQ-013 pc  output  32  current fetch PC.
REQ-014 if_id_pc  output  32  PC of the instruction held in IF/ID.
REQ-015 if_id_pc_plus4  output  32  if_id_pc + 4.
REQ-016 if_id_instr  output  32  instruction held in IF/ID.
REQ-017 if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-018 fetch_count  output  32  number of instructions delivered to IF/ID as valid.

Function
REQ-019 next_pc priority: branch_taken -> branch_target; else jump -> jump_target; else stall -> pc; else pc + 4.
REQ-020 Redirects (branch_taken or jump) update the PC even when stall is high.
REQ-021 Targets have bits [1:0] forced to 0 before loading into pc.
REQ-022 pc + 4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-023 imem_addr = pc[11:2] combinationally; addresses above 4 KB alias without error.
REQ-024 IF/ID update priority: flush or branch_taken or jump -> load bubble (pc fields = pc, instr = NOP_INSTR, valid = 0); else stall -> hold all IF/ID fields; else load {pc, pc+4, imem_rdata, valid = 1}.
REQ-025 Fetch latency is one cycle: an instruction at pc in cycle N appears on if_id_* in cycle N+1.
REQ-026 fetch_count increments by 1 on each edge where IF/ID loads valid = 1 and wraps at 2^32; it does not change on stall or bubble.
REQ-027 Simultaneous stall and flush: bubble inserted, PC held unless a redirect is also present.
REQ-028 Simultaneous branch_taken and jump: branch_taken wins and jump is discarded.

Reset
REQ-029 While rst_n = 0: pc = PC_RESET, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_instr = NOP_INSTR, if_id_valid = 0, fetch_count = 0.
REQ-030 Reset asserts immediately without waiting for a clock edge, and interrupts any in-flight redirect or stall.
REQ-031 First rising edge after rst_n deasserts loads the instruction at PC_RESET into IF/ID and advances pc to PC_RESET + 4, unless stall, flush or redirect is asserted.

Structure
REQ-032 `NOP, PC width and IMem address-width constants reside in the shared const.vh include.
REQ-033 The IF/ID register (stall/flush/valid handling) is one sub-module named if_id_reg; next-PC logic and pc register stay in if_stage.

Verification
REQ-034 Reset release with PC_RESET = 0, no hazards: pc steps 0, 4, 8, 12; if_id_pc lags by one cycle; if_id_valid = 1 from the 1st edge; fetch_count = 3 after 3 edges.
REQ-035 stall high for 2 cycles at pc = 8: pc stays 8 and IF/ID holds instr@4 for 2 cycles; fetch_count frozen; resumes with 12.
REQ-036 branch_taken = 1 with target 32'h0000_0043 at pc = 16: next pc = 32'h40; IF/ID bubble (valid = 0, instr = NOP); next cycle IF/ID = instr@0x40.
REQ-037 branch_taken and jump (target 0x80) with stall in one cycle, branch_target = 0x20: pc = 0x20; IF/ID bubble.
REQ-038 pc = 32'hFFFF_FFFC, no hazards: next pc = 0; imem_addr = 10'h3FF, then 10'h000.
REQ-039 rst_n pulsed low mid-cycle during stall: outputs reach reset values asynchronously; after release, fetch restarts at PC_RESET.
